decode_ctl: RTL and testbench

Front-end controller that sequences instructions into `decode`. It buffers fetched instructions in a small in-order queue and tracks in-flight destination registers in a scoreboard. It presents one instruction per cycle at de0 only when that instruction has no RAW hazard and downstream is ready. It sits between fetch and `decode`, and takes flush from the back end and register-write notifications from writeback.

---
 rtl/decode_ctl_pkg.sv | 52 +++++
 rtl/decode_ctl_fifo.sv | 47 ++++
 rtl/decode_ctl.sv | 110 +++++++++++
 tb/tb_decode_ctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctl_pkg.sv
// Shared instruction-decode types: RV32 instruction/format types, decode-control
// FSM states and per-format register usage helpers.
package instr_decode;

  typedef logic [31:0] t_rv_instr;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} t_rv_instr_format;

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} t_dctl_state;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } t_src_usage;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Unlisted opcodes (fence/system) fall back to I-type register usage.
  function automatic t_rv_instr_format get_instr_format(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:               return FMT_R;
      OPC_STORE:            return FMT_S;
      OPC_BRANCH:           return FMT_B;
      OPC_LUI, OPC_AUIPC:   return FMT_U;
      OPC_JAL:              return FMT_J;
      default:              return FMT_I;
    endcase
  endfunction

  function automatic t_src_usage get_src_usage(input t_rv_instr_format fmt);
    t_src_usage u;
    u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b0};
    case (fmt)
      FMT_R:        u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
      FMT_S, FMT_B: u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
      FMT_I:        u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
      FMT_U, FMT_J: u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
      default:      u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b0};
    endcase
    return u;
  endfunction

endpackage

// File: rtl/decode_ctl_fifo.sv
// dctl_fifo: circular in-order FIFO with synchronous flush; exposes the head
// entry and occupancy count.
module dctl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic             w_clr;

  assign w_clr = reset | i_flush;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !w_clr) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/decode_ctl.sv
// decode_ctl: queues fetched instructions and issues the head to decode when it
// has no RAW/WAW hazard. Define DECODE_CTL_WB_BYPASS_EN to let a same-cycle
// writeback release a dependent instruction.
module decode_ctl
  import instr_decode::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_fe,
  input  t_rv_instr           instr_fe,
  output logic                ready_fe,
  output logic                valid_de0,
  output t_rv_instr           instr_de0,
  input  logic                ready_de0,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_sb
);

  localparam int CW = $clog2(DEPTH) + 1;

  t_dctl_state         r_state;
  t_dctl_state         w_state_nxt;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic [CW-1:0]       w_count;
  t_rv_instr           w_head;
  t_rv_instr_format    w_fmt;
  t_src_usage          w_use;
  logic [4:0]          w_rs1;
  logic [4:0]          w_rs2;
  logic [4:0]          w_rd;
  logic                w_nonempty;
  logic                w_hazard;
  logic                w_stall;
  logic                w_push;

  dctl_fifo #(.DEPTH(DEPTH), .WIDTH($bits(t_rv_instr))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (valid_de0),
    .i_flush (flush),
    .i_data  (instr_fe),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_nonempty = (w_count != '0);
  assign w_fmt      = get_instr_format(w_head[6:0]);
  assign w_use      = get_src_usage(w_fmt);
  assign w_rs1      = w_head[19:15];
  assign w_rs2      = w_head[24:20];
  assign w_rd       = w_head[11:7];

`ifdef DECODE_CTL_WB_BYPASS_EN
  assign w_busy_eff = r_busy & ~(NUM_REGS'(wb_valid) << wb_rd);
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_hazard = (w_use.rs1 && (w_rs1 != 5'd0) && w_busy_eff[w_rs1]) ||
                    (w_use.rs2 && (w_rs2 != 5'd0) && w_busy_eff[w_rs2]) ||
                    (w_use.rd  && (w_rd  != 5'd0) && w_busy_eff[w_rd]);
  assign w_stall  = w_nonempty & w_hazard;

  // HOLD throttles fetch only; issue follows the live hazard so a release
  // issues without waiting for the state register to return to RUN.
  assign ready_fe  = ~reset & (w_count < CW'(DEPTH)) & (r_state == RUN);
  assign valid_de0 = ~reset & ~flush & (r_state != FLUSH) & ~w_stall &
                     w_nonempty & ready_de0;
  assign instr_de0 = w_nonempty ? w_head : '0;
  assign w_push    = valid_fe & ready_fe & ~flush;
  assign busy_sb   = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_stall)  w_state_nxt = HOLD;
      HOLD:    if (!w_stall) w_state_nxt = RUN;
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    if (flush) w_state_nxt = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Issue set is applied after the writeback clear so it wins on a collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_rd] = 1'b0;
    if (valid_de0 && w_use.rd) w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) r_busy <= '0;
    else                r_busy <= w_busy_nxt;
  end

endmodule

// File: tb/tb_decode_ctl.sv
// Self-checking bench for decode_ctl: directed scenarios then randomized traffic,
// every cycle compared against a queue/scoreboard reference model.
module tb_decode_ctl;
  import instr_decode::*;

  localparam int DEPTH = 4;
`ifdef DECODE_CTL_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                     7'b0100011, 7'b1100011, 7'b0110111,
                                     7'b0010111, 7'b1101111, 7'b1100111};

  logic        clk, reset, valid_fe, ready_fe, valid_de0, ready_de0;
  logic        wb_valid, flush;
  t_rv_instr   instr_fe, instr_de0;
  logic [4:0]  wb_rd;
  logic [31:0] busy_sb;

  decode_ctl #(.DEPTH(DEPTH), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .valid_fe(valid_fe), .instr_fe(instr_fe),
    .ready_fe(ready_fe), .valid_de0(valid_de0), .instr_de0(instr_de0),
    .ready_de0(ready_de0), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_sb(busy_sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  t_rv_instr   mq[$];
  logic [31:0] mbusy = '0;
  bit          mstall = 1'b0;
  bit          mflush = 1'b0;

  logic        obs_ready, obs_valid;
  t_rv_instr   obs_instr;
  logic [31:0] obs_busy;

  function automatic t_rv_instr addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic t_rv_instr add(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  // Register usage from the RISC-V base opcode map: {rs1, rs2, rd}
  function automatic logic [2:0] usage(input t_rv_instr i);
    case (i[6:0])
      7'b0110011:                         return 3'b111;
      7'b0100011, 7'b1100011:             return 3'b110;
      7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;
      default:                            return 3'b101;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(input logic rst, input logic fl, input logic vfe, input t_rv_instr ins,
                     input logic rdy, input logic wbv, input logic [4:0] wrd);
    logic [31:0] eff;
    logic [2:0]  u;
    t_rv_instr   hd;
    logic        ne, eh, er, ev;
    reset = rst; flush = fl; valid_fe = vfe; instr_fe = ins;
    ready_de0 = rdy; wb_valid = wbv; wb_rd = wrd;
    #2;
    eff = mbusy;
    if (BYPASS && wbv) eff[wrd] = 1'b0;
    ne = (mq.size() != 0);
    hd = ne ? mq[0] : '0;
    u  = usage(hd);
    eh = ne && ((u[2] && hd[19:15] != 0 && eff[hd[19:15]]) ||
                (u[1] && hd[24:20] != 0 && eff[hd[24:20]]) ||
                (u[0] && hd[11:7]  != 0 && eff[hd[11:7]]));
    er = !rst && (mq.size() < DEPTH) && !mstall && !mflush;
    ev = !rst && !fl && !mflush && ne && !eh && rdy;
    obs_ready = ready_fe; obs_valid = valid_de0; obs_instr = instr_de0; obs_busy = busy_sb;
    chk("ready_fe", {31'd0, obs_ready}, {31'd0, er});
    chk("valid_de0", {31'd0, obs_valid}, {31'd0, ev});
    chk("instr_de0", obs_instr, hd);
    chk("busy_sb", obs_busy, mbusy);
    @(posedge clk);
    if (rst || fl) begin
      mq.delete();
      mbusy  = '0;
      mstall = 1'b0;
      mflush = !rst;
    end else begin
      if (wbv) mbusy[wrd] = 1'b0;
      if (ev) begin
        void'(mq.pop_front());
        if (u[0]) mbusy[hd[11:7]] = 1'b1;
        mbusy[0] = 1'b0;
      end
      if (vfe && er) mq.push_back(ins);
      mstall = eh;
      mflush = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, '0, rdy, 1'b0, 5'd0);
  endtask

  task automatic wb(input logic [4:0] r);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, r);
  endtask

  task automatic push(input t_rv_instr i, input logic rdy);
    cyc(1'b0, 1'b0, 1'b1, i, rdy, 1'b0, 5'd0);
  endtask

  initial begin
    t_rv_instr ri;
    reset = 1'b1; flush = 1'b0; valid_fe = 1'b0; instr_fe = '0;
    ready_de0 = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    @(posedge clk); #1;

    // Reset values
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 5'd0);
    chk("rst_cycle_ready", {31'd0, obs_ready}, 32'd0);
    idle(1'b1);
    chk("post_rst_ready", {31'd0, obs_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, obs_valid}, 32'd0);
    chk("post_rst_instr", obs_instr, 32'd0);
    chk("post_rst_busy", obs_busy, 32'd0);

    // Four independent ADDIs stream through at one per cycle
    for (int k = 1; k <= 4; k++) begin
      push(addi(5'(k), 5'd0), 1'b1);
      chk("stream_valid", {31'd0, obs_valid}, (k == 1) ? 32'd0 : 32'd1);
      if (k > 1) chk("stream_instr", obs_instr, addi(5'(k - 1), 5'd0));
    end
    idle(1'b1);
    chk("stream_last", obs_instr, addi(5'd4, 5'd0));
    idle(1'b1);
    chk("stream_done", {31'd0, obs_valid}, 32'd0);
    chk("stream_busy", obs_busy, 32'h1E);
    for (int k = 1; k <= 4; k++) wb(5'(k));

    // Fill with downstream stalled, then drain in order
    for (int k = 0; k < 4; k++) begin
      push(addi(5'(5 + k), 5'd0), 1'b0);
      chk("fill_ready", {31'd0, obs_ready}, 32'd1);
    end
    chk("fill_busy_clear", obs_busy, 32'd0);
    push(addi(5'd9, 5'd0), 1'b0);
    chk("full_ready", {31'd0, obs_ready}, 32'd0);
    push(addi(5'd9, 5'd0), 1'b0);
    chk("full_ready_hold", {31'd0, obs_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("drain_valid", {31'd0, obs_valid}, 32'd1);
      chk("drain_instr", obs_instr, addi(5'(5 + k), 5'd0));
    end
    idle(1'b1);
    chk("drain_empty", {31'd0, obs_valid}, 32'd0);
    for (int k = 5; k <= 8; k++) wb(5'(k));

    // RAW hazard released by writeback
    push(add(5'd5, 5'd1, 5'd2), 1'b1);
    push(add(5'd6, 5'd5, 5'd1), 1'b1);
    chk("raw_first_issue", obs_instr, add(5'd5, 5'd1, 5'd2));
    idle(1'b1);
    chk("raw_stall", {31'd0, obs_valid}, 32'd0);
    idle(1'b1);
    chk("hold_ready", {31'd0, obs_ready}, 32'd0);
    wb(5'd5);
    chk("wb_cycle_issue", {31'd0, obs_valid}, {31'd0, BYPASS});
    if (!BYPASS) begin
      idle(1'b1);
      chk("wb_next_issue", {31'd0, obs_valid}, 32'd1);
      chk("wb_next_instr", obs_instr, add(5'd6, 5'd5, 5'd1));
    end
    idle(1'b1);
    chk("raw_busy_after", obs_busy, 32'h40);
    wb(5'd6);

    // rd = x0 never marks busy; rs1 = x0 never stalls
    push(addi(5'd0, 5'd0), 1'b1);
    push(addi(5'd3, 5'd0), 1'b1);
    chk("x0_issue", {31'd0, obs_valid}, 32'd1);
    idle(1'b1);
    chk("x0_next_issue", {31'd0, obs_valid}, 32'd1);
    chk("x0_busy", obs_busy, 32'd0);
    wb(5'd3);

    // Flush with three queued and x5/x6 in flight
    push(addi(5'd5, 5'd0), 1'b1);
    push(addi(5'd6, 5'd0), 1'b1);
    idle(1'b1);
    for (int k = 1; k <= 3; k++) push(addi(5'(k), 5'd0), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, addi(5'd9, 5'd0), 1'b1, 1'b1, 5'd5);
    chk("flush_busy_before", obs_busy, 32'h60);
    chk("flush_valid_n", {31'd0, obs_valid}, 32'd0);
    push(addi(5'd10, 5'd0), 1'b1);
    chk("flush_valid_n1", {31'd0, obs_valid}, 32'd0);
    chk("flush_ready_n1", {31'd0, obs_ready}, 32'd0);
    chk("flush_busy_n1", obs_busy, 32'd0);
    chk("flush_instr_n1", obs_instr, 32'd0);
    push(addi(5'd7, 5'd0), 1'b1);
    chk("flush_ready_n2", {31'd0, obs_ready}, 32'd1);
    idle(1'b1);
    chk("flush_refill", obs_instr, addi(5'd7, 5'd0));
    wb(5'd7);

    // Reset while holding on a hazard
    push(add(5'd5, 5'd1, 5'd2), 1'b1);
    push(add(5'd6, 5'd5, 5'd1), 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("pre_rst_hold", {31'd0, obs_ready}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 5'd0);
    idle(1'b1);
    chk("hold_rst_ready", {31'd0, obs_ready}, 32'd1);
    chk("hold_rst_valid", {31'd0, obs_valid}, 32'd0);
    chk("hold_rst_instr", obs_instr, 32'd0);
    chk("hold_rst_busy", obs_busy, 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      ri = $urandom;
      ri[6:0]   = OPS[$urandom_range(0, 8)];
      ri[11:7]  = 5'($urandom_range(0, 7));
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) != 0), ri, ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
